// File: rtl/ram_dma_pkg.sv
// rtl/ram_dma_pkg.sv - shared widths, op encodings and FSM states for ram_dma
package ram_dma_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 14;
    localparam int LEN_W  = 15;

    localparam logic OP_FILL = 1'b0;
    localparam logic OP_COPY = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RD,
        WR,
        DONE
    } state_t;
endpackage

// File: rtl/ram_dma_mux.sv
// rtl/ram_dma_mux.sv - selects the ram16k port between the DMA engine and the CPU
module ram_dma_mux
    import ram_dma_pkg::*;
(
    input  logic              sel,
    input  logic [ADDR_W-1:0] eng_address,
    input  logic [DATA_W-1:0] eng_in,
    input  logic              eng_load,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_in,
    input  logic              cpu_load,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_load
);
    // While the engine owns the port, CPU writes are simply dropped.
    assign mem_address = sel ? eng_address : cpu_address;
    assign mem_in      = sel ? eng_in      : cpu_in;
    assign mem_load    = sel ? eng_load    : cpu_load;
endmodule

// File: rtl/ram_dma.sv
// rtl/ram_dma.sv - FILL/COPY block-transfer engine in front of ram16k
module ram_dma
    import ram_dma_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] fill_val,
    output logic              busy,
    output logic              done,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_in,
    input  logic              cpu_load,
    output logic [DATA_W-1:0] cpu_out,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_load,
    input  logic [DATA_W-1:0] mem_out
);
    state_t            state;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [LEN_W-1:0]  count;
    logic [DATA_W-1:0] data_reg;
    logic [DATA_W-1:0] fill_reg;

    logic [ADDR_W-1:0] eng_address;
    logic [DATA_W-1:0] eng_in;
    logic              eng_load;

    always_comb begin
        eng_address = (state == RD) ? src_ptr : dst_ptr;
        eng_in      = (state == FILL) ? fill_reg : data_reg;
        eng_load    = (state == FILL) || (state == WR);
    end

    // Releasing the port during reset keeps an aborted transfer from landing one more word.
    ram_dma_mux u_mux (
        .sel         (busy && !reset),
        .eng_address (eng_address),
        .eng_in      (eng_in),
        .eng_load    (eng_load),
        .cpu_address (cpu_address),
        .cpu_in      (cpu_in),
        .cpu_load    (cpu_load),
        .mem_address (mem_address),
        .mem_in      (mem_in),
        .mem_load    (mem_load)
    );

    assign cpu_out = mem_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            src_ptr  <= '0;
            dst_ptr  <= '0;
            count    <= '0;
            data_reg <= '0;
            fill_reg <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        src_ptr  <= src;
                        dst_ptr  <= dst;
                        count    <= len;
                        fill_reg <= fill_val;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= (op == OP_FILL) ? FILL : RD;
                            busy  <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    dst_ptr <= dst_ptr + ADDR_W'(1);
                    count   <= count - LEN_W'(1);
                    if (count == LEN_W'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                RD: begin
                    data_reg <= mem_out;
                    src_ptr  <= src_ptr + ADDR_W'(1);
                    state    <= WR;
                end
                WR: begin
                    dst_ptr <= dst_ptr + ADDR_W'(1);
                    count   <= count - LEN_W'(1);
                    if (count == LEN_W'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= RD;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/ram_dma.md
Name: ram_dma

Overview:
Block-transfer engine sitting directly upstream of ram16k; drives ram16k's in/address/load and consumes its out.
- Executes two operations over a range of words: FILL (write a constant) and COPY (ascending word-by-word copy).
- When idle, passes the CPU-side memory port straight through to ram16k.
- Used for screen/buffer clears and block moves without CPU involvement.

Parameters:
DATA_W, 16, word width
ADDR_W, 14, address width (16384 words)
LEN_W, 15, length width (ADDR_W+1, allows len = 16384)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request pulse; sampled only in IDLE
op  in  1  0 = FILL, 1 = COPY; sampled with start
src  in  ADDR_W  COPY source base; sampled with start
dst  in  ADDR_W  destination base (FILL and COPY); sampled with start
len  in  LEN_W  word count 0..16384; sampled with start
fill_val  in  DATA_W  FILL value; sampled with start
busy  out  1  high in FILL/RD/WR
done  out  1  one-cycle completion pulse
cpu_address  in  ADDR_W  CPU address, passed through when not busy
cpu_in  in  DATA_W  CPU write data, passed through when not busy
cpu_load  in  1  CPU write enable, passed through when not busy
cpu_out  out  DATA_W  equals mem_out at all times
mem_address  out  ADDR_W  to ram16k address
mem_in  out  DATA_W  to ram16k in
mem_load  out  1  to ram16k load
mem_out  in  DATA_W  from ram16k out (combinational read of mem_address)

Behaviour:
- States: IDLE, FILL, RD, WR, DONE. Registered state, ptrs (src_ptr, dst_ptr), remaining count, data_reg, fill_reg.
- Reset (synchronous, checked first at every edge): state=IDLE, ptrs=0, count=0, data_reg=0, busy=0, done=0.
  - mem_* follow cpu_* after reset.
  - Reset mid-operation aborts immediately: no further writes; already-written words remain; no done pulse.
- IDLE: mem_* = cpu_*.
  - start=1 at an edge latches op/src/dst/len/fill_val.
  - len=0 -> DONE.
  - op=FILL -> FILL; op=COPY -> RD.
- FILL: mem_address=dst_ptr, mem_in=fill_reg, mem_load=1.
  - Each edge: dst_ptr++, count--.
  - When count reaches 0 after the write -> DONE.
  - Throughput: 1 word/cycle; N words occupy N cycles.
- RD: mem_address=src_ptr, mem_load=0. Edge: data_reg<=mem_out, src_ptr++ -> WR.
- WR: mem_address=dst_ptr, mem_in=data_reg, mem_load=1. Edge: dst_ptr++, count--.
  - count reaches 0 -> DONE; otherwise -> RD.
  - Throughput: 2 cycles/word; N words occupy 2N cycles.
- DONE: done=1 and busy=0 for exactly one cycle; mem_* = cpu_*. Next edge -> IDLE.
  - start in DONE is ignored.
- start while busy (FILL/RD/WR) is ignored; no queuing.
- CPU writes issued while busy are dropped (cpu_load not forwarded); cpu_out still shows mem_out.
- Pointer arithmetic is modulo 2^ADDR_W: address 16383 wraps to 0.
- len=16384 covers the whole RAM exactly once.
- Overlap: COPY is strictly ascending and each RD sees all prior WR.
  - With dst in (src, src+len), the source pattern repeats with period dst-src. This is the defined result.
- Latency: start edge T -> first write at edge T+1 (FILL) or T+2 (COPY); done high in cycle after last write edge.
- mem_load is never asserted in RD, DONE, or after reset.

Decomposition:
- Package ram_dma_pkg: DATA_W/ADDR_W/LEN_W constants; OP_FILL/OP_COPY encodings; state enum (IDLE, FILL, RD, WR, DONE).
- One sub-module, ram_dma_mux: combinational selection of mem_* between the engine and cpu_* on busy.
- FSM, pointers and counter live in ram_dma.

Test Plan:
- FILL: dst=100, len=4, fill_val=16'hBEEF -> mem_load high 4 consecutive cycles at addresses 100..103; done pulses once 1 cycle later; RAM[99] and RAM[104] unchanged.
- COPY: preload RAM[0..2]=1,2,3; src=0, dst=200, len=3 -> busy 6 cycles; RAM[200..202]=1,2,3; done pulses once.
- Wrap and len=0: FILL dst=16382, len=3, val=7 -> RAM[16382], RAM[16383], RAM[0]=7. Separately, len=0 -> done the cycle after start, no mem_load.
- Overlap: RAM[10]=5, RAM[11]=6; COPY src=10, dst=11, len=3 -> RAM[11..13]=5,5,5.
- Reset mid-op: FILL dst=0, len=8, val=9, reset after 3 writes -> RAM[0..2]=9, RAM[3..7] unchanged; done never pulses; busy=0 after reset edge; cpu_* passes through.
- Contention: start during busy ignored (no second transfer). cpu_load=1 during busy does not write. After done, a CPU write to 50 of 16'h1234 lands and reads back via cpu_out.
